smart_bus_drain: RTL
====================

# smart_bus_drain

Edge collector at the bottom of one systolic-array column that drains output-stationary results off the vertical smart bus. On `start_in` it walks the column's rows in order, asserts each row's `select_bottom_out_smart` for one capture cycle, samples `vertical_smart_bus_in`, and buffers the word with its row tag. The buffered results stream out through a valid/ready port to the output buffer. It is the reading end of the bus that the smart MACs write when their bottom-out select is set.

## Interface
- `WORD_SIZE`, 16, bus/result word width
- `NUM_ROWS`, 8, rows in the column (≥2)
- `FIFO_DEPTH`, 4, result buffer entries (power of two, ≥2)

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset; synchronous, active-high
- `start_in`  in  1  one-cycle pulse, begin drain; ignored unless IDLE
- `busy_out`  out  1  high from the cycle after accepted start until done
- `done_out`  out  1  one-cycle pulse, all rows delivered downstream
- `select_bottom_out_smart`  out  NUM_ROWS  one-hot/zero, bit r drives row r MAC onto bus
- `vertical_smart_bus_in`  in  WORD_SIZE  bus value arriving at column bottom
- `result_out`  out  WORD_SIZE  FIFO head word
- `row_idx_out`  out  $clog2(NUM_ROWS)  row tag of head word
- `result_valid_out`  out  1  FIFO non-empty
- `result_ready_in`  in  1  downstream accept

## Operation
- FSM states: IDLE, DRAIN, FLUSH.
- IDLE: select = 0, busy = 0. `start_in`=1 → DRAIN, row counter = 0.
- DRAIN, FIFO not full: select = one-hot(row); on the clock edge, push {row, `vertical_smart_bus_in`}; row++. Push of row NUM_ROWS-1 → FLUSH.
- DRAIN, FIFO full: select = 0, no push, row holds (stall). Fullness is evaluated from the registered count; a same-cycle pop does not enable a push.
- FLUSH: select = 0; when FIFO empty → `done_out`=1 for one cycle, → IDLE.
- Pop: `result_valid_out` && `result_ready_in` on an edge removes the head. Push and pop in the same cycle leave count unchanged.
- `start_in` in DRAIN/FLUSH: ignored; no restart, no error.
- `select_bottom_out_smart` is never multi-hot. It is a registered-state decode and is glitch-free relative to `clk`.
- Head outputs hold when valid && !ready. When the FIFO is empty, `result_out`/`row_idx_out` are don't-care; the bench must not check them.
- Reset (any state, mid-drain included): state IDLE, row 0, FIFO emptied, select 0, `busy_out` 0, `done_out` 0, `result_valid_out` 0. Buffered words are discarded.

## Timing
- Bus sample is combinational within the select cycle. The MAC `bottom_out` is registered, and the smart bus mux chain must settle in one cycle.
- Start accepted at edge t → row 0 select asserted in cycle t+1 → first result valid in cycle t+2.
- With `result_ready_in` held high: one row per cycle, no stalls. `done_out` is asserted in cycle t+NUM_ROWS+2, which is the cycle after the last pop edge.
- Minimum start-to-start interval: NUM_ROWS+3 cycles.
- `busy_out` = (state != IDLE), registered.

## Structure
- Shared package `smart_array_pkg`:
  - `drain_state_t` enum (IDLE, DRAIN, FLUSH)
  - `ROW_IDX_W` localparam/function from NUM_ROWS
- Sub-module `drain_fifo`:
  - synchronous FIFO, width WORD_SIZE+ROW_IDX_W, depth FIFO_DEPTH
  - ports: push/pop/full/empty/head
  - count register of $clog2(FIFO_DEPTH)+1 bits; pointers wrap at FIFO_DEPTH.
- Top: FSM, row counter, one-hot decode, FIFO instance.

## Test plan
- Free-flow: NUM_ROWS=8, row r bus model returns 16'h0A00+r, ready=1. Required response:
  - 8 results in order, tags 0..7, with values 16'h0A00..16'h0A07
  - one select bit per cycle
  - `done_out` exactly once, in cycle t+10.
- Backpressure: ready=0 throughout DRAIN. Required response:
  - exactly 4 pushes (rows 0–3), then select = 0
  - after ready rises, rows 4–7 drain in order, with no lost or duplicated tags.
- Simultaneous push/pop at count=3: count stays 3, head advances; with ready toggling 1/0 per cycle, the output order is still 0..7.
- Start during busy: second `start_in` pulse in DRAIN and in FLUSH → ignored; exactly 8 results and one `done_out`.
- Reset mid-drain: `rst` after 3 pushes with ready=0. Required response:
  - next cycle: valid=0, select=0, busy=0
  - a new start yields 8 results beginning with tag 0.
- Wrap-around: two back-to-back drains with ready random 50% → 16 results, correct tags each drain, FIFO pointers wrap without data corruption.

Source files
------------

// File: rtl/smart_bus_drain_pkg.sv
// Shared types and helpers for the systolic-array column drain logic.
// Latency: n/a (types only).
// Backpressure: n/a.
// Contents: drain FSM state enum and the row-tag width helper.
package smart_array_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } drain_state_t;

  // Row tag width; at least one bit so a tag field always exists.
  function automatic int row_idx_w(input int num_rows);
    return (num_rows < 2) ? 1 : $clog2(num_rows);
  endfunction

endpackage

// File: rtl/smart_bus_drain_if.sv
// Column-bottom bundle: smart-bus select/sample plus the result stream.
// Latency: n/a (wiring only).
// Backpressure: result stream is valid/ready; master holds the head while !ready.
// Ports: select_bottom_out_smart, vertical_smart_bus_in, result_out,
//        row_idx_out, result_valid_out, result_ready_in.
interface smart_bus_drain_if #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_ROWS  = 8
);
  import smart_array_pkg::*;

  localparam int ROW_IDX_W = row_idx_w(NUM_ROWS);

  logic [NUM_ROWS-1:0]  select_bottom_out_smart;
  logic [WORD_SIZE-1:0] vertical_smart_bus_in;
  logic [WORD_SIZE-1:0] result_out;
  logic [ROW_IDX_W-1:0] row_idx_out;
  logic                 result_valid_out;
  logic                 result_ready_in;

  // Drain side: drives selects and the result stream.
  modport master (
    output select_bottom_out_smart,
    input  vertical_smart_bus_in,
    output result_out,
    output row_idx_out,
    output result_valid_out,
    input  result_ready_in
  );

  // Array/output-buffer side.
  modport slave (
    input  select_bottom_out_smart,
    output vertical_smart_bus_in,
    input  result_out,
    input  row_idx_out,
    input  result_valid_out,
    output result_ready_in
  );

endinterface

// File: rtl/smart_bus_drain_fifo.sv
// Small synchronous FIFO buffering {row tag, result word} pairs.
// Latency: push visible at head the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; simultaneous push+pop keeps count.
// Ports: clk, rst, push_in, push_dat_in, pop_in, full_out, empty_out, head_out.
module drain_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_in,
  input  logic [WIDTH-1:0] push_dat_in,
  input  logic             pop_in,
  output logic             full_out,
  output logic             empty_out,
  output logic [WIDTH-1:0] head_out
);

  localparam int PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign full_out  = (r_count == CNT_W'(DEPTH));
  assign empty_out = (r_count == '0);
  assign head_out  = r_mem[r_rd_ptr];

  assign w_push_ok = push_in && !full_out;
  assign w_pop_ok  = pop_in  && !empty_out;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= push_dat_in;
  end

endmodule

// File: rtl/smart_bus_drain.sv
// Column-bottom collector: walks rows, selects each MAC onto the smart bus, buffers and streams results.
// Latency: start edge t -> row 0 select in next cycle -> first result valid one cycle later.
// Backpressure: FIFO full stalls the row walk (select drops to 0); head holds while valid && !ready.
// Ports: clk, rst, start_in, busy_out, done_out, bus (master modport of smart_bus_drain_if).
module smart_bus_drain
  import smart_array_pkg::*;
#(
  parameter int WORD_SIZE  = 16,
  parameter int NUM_ROWS   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_in,
  output logic               busy_out,
  output logic               done_out,
  smart_bus_drain_if.master  bus
);

  localparam int ROW_IDX_W = row_idx_w(NUM_ROWS);
  localparam int FW        = WORD_SIZE + ROW_IDX_W;
  localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(NUM_ROWS - 1);

  drain_state_t         r_state;
  drain_state_t         w_state_nxt;
  logic [ROW_IDX_W-1:0] r_row;
  logic [ROW_IDX_W-1:0] w_row_nxt;
  logic                 r_busy;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_done;
  logic [NUM_ROWS-1:0]  w_sel;
  logic [FW-1:0]        w_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  // Select and push depend only on registered state and registered FIFO
  // count, so the decode is clean within the cycle and a same-cycle pop
  // never opens room for a push.
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_push      = 1'b0;
    w_sel       = '0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_in) begin
          w_state_nxt = DRAIN;
          w_row_nxt   = '0;
        end
      end
      DRAIN: begin
        if (!w_full) begin
          w_push = 1'b1;
          w_sel  = {{(NUM_ROWS-1){1'b0}}, 1'b1} << r_row;
          if (r_row == LAST_ROW) begin
            w_state_nxt = FLUSH;
            w_row_nxt   = '0;
          end else begin
            w_row_nxt = r_row + ROW_IDX_W'(1);
          end
        end
      end
      FLUSH: begin
        if (w_empty) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_pop = !w_empty && bus.result_ready_in;

  drain_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_in     (w_push),
    .push_dat_in ({r_row, bus.vertical_smart_bus_in}),
    .pop_in      (w_pop),
    .full_out    (w_full),
    .empty_out   (w_empty),
    .head_out    (w_head)
  );

  assign bus.select_bottom_out_smart = w_sel;
  assign bus.result_out              = w_head[WORD_SIZE-1:0];
  assign bus.row_idx_out             = w_head[FW-1:WORD_SIZE];
  assign bus.result_valid_out        = !w_empty;
  assign busy_out                    = r_busy;
  assign done_out                    = w_done;

endmodule
